// File: rtl/scsiaccess_mc.sv
// ---------------------------------------------------------------------------
// scsiaccess_mc
//
// Sequences register accesses from the host bus to up to NCH SCSI controller
// chips. A decoded register cycle (scsi_cycle) with a one-hot chan_sel runs
// through address strobe, chip select and acknowledge phases. A missing slave
// acknowledge within TIMEOUT chip-select cycles ends the access with a bus
// error. All state changes happen on the falling edge of bclk, and every
// output comes straight from a flop.
//
// Ports
//   bclk        in   bus clock, active on its falling edge
//   reset       in   asynchronous, active-high reset
//   scsi_cycle  in   decoded register-access cycle (level)
//   chan_sel    in   [NCH] one-hot target channel select
//   DOE         in   data output enable from the bus
//   DS_n        in   [4] bus byte strobes, active low
//   READ        in   1 = read, 0 = write
//   mybus       in   board is bus master (DMA), sequencing suppressed
//   SLACK_n     in   [NCH] per-channel slave acknowledge, active low
//   SCSI_SREG_n out  [NCH] per-channel register chip select, active low
//   scsi_as_sig out  address strobe to the chips
//   scsi_ds_sig out  data strobe to the chips
//   dtack       out  cycle acknowledge to the bus
//   berr        out  bus error to the bus
// ---------------------------------------------------------------------------
module scsiaccess_mc #(
    parameter int NCH      = 2,
    parameter int DS_DELAY = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic           bclk,
    input  logic           reset,
    input  logic           scsi_cycle,
    input  logic [NCH-1:0] chan_sel,
    input  logic           DOE,
    input  logic [3:0]     DS_n,
    input  logic           READ,
    input  logic           mybus,
    input  logic [NCH-1:0] SLACK_n,
    output logic [NCH-1:0] SCSI_SREG_n,
    output logic           scsi_as_sig,
    output logic           scsi_ds_sig,
    output logic           dtack,
    output logic           berr
);

    localparam int         CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] AS_LAST = 4'(DS_DELAY);
    // The CS counter "reaches" TIMEOUT on the edge where it would step past
    // TIMEOUT-1, so the comparison is made against the last in-range value.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TO_FULL = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AS,
        S_CS,
        S_ACK,
        S_TOUT
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            rd_q, rd_d;
    logic [3:0]      as_cnt_q, as_cnt_d;
    logic [7:0]      cs_cnt_q, cs_cnt_d;

    logic [NCH-1:0]  sreg_n_q, sreg_n_d;
    logic            as_q, as_d;
    logic            ds_q, ds_d;
    logic            dtack_q, dtack_d;
    logic            berr_q, berr_d;

    logic [CH_W-1:0] sel_idx;
    logic            sel_onehot;
    logic            start;
    logic            slack_hit;
    logic            as_done;

    // Encode the one-hot select into a channel index.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_sel[i]) sel_idx = CH_W'(i);
        end
    end

    assign sel_onehot = $onehot(chan_sel);
    assign start      = scsi_cycle & ~mybus & DOE & (DS_n != 4'hF) & sel_onehot;
    // Only the acknowledge of the latched channel counts.
    assign slack_hit  = ~SLACK_n[ch_q];
    // Reads hold AS for a single cycle; writes wait DS_DELAY cycles.
    assign as_done    = rd_q | (as_cnt_q >= AS_LAST);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rd_d     = rd_q;
        as_cnt_d = as_cnt_q;
        cs_cnt_d = cs_cnt_q;

        if (!scsi_cycle || mybus) begin
            // End of the bus cycle, or DMA ownership, aborts any sequence.
            state_d  = S_IDLE;
            as_cnt_d = '0;
            cs_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_AS;
                        ch_d     = sel_idx;
                        rd_d     = READ;
                        as_cnt_d = 4'd1;
                        cs_cnt_d = '0;
                    end
                end
                S_AS: begin
                    if (as_done) begin
                        state_d  = S_CS;
                        cs_cnt_d = '0;
                    end else begin
                        as_cnt_d = as_cnt_q + 4'd1;
                    end
                end
                S_CS: begin
                    // Acknowledge takes priority over a coincident timeout.
                    if (slack_hit) begin
                        state_d = S_ACK;
                    end else if (cs_cnt_q >= TO_LAST) begin
                        state_d  = S_TOUT;
                        cs_cnt_d = TO_FULL;
                    end else begin
                        cs_cnt_d = cs_cnt_q + 8'd1;
                    end
                end
                S_ACK:   state_d = S_ACK;
                S_TOUT:  state_d = S_TOUT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge that enters each phase.
    always_comb begin
        sreg_n_d = '1;
        if (state_d == S_CS || state_d == S_ACK) begin
            sreg_n_d[ch_d] = 1'b0;
        end
        // DMA pass-through: channel 0 chip select follows the bus directly.
        if (scsi_cycle && mybus) begin
            sreg_n_d[0] = 1'b0;
        end
        as_d    = (state_d == S_AS) || (state_d == S_CS) || (state_d == S_ACK);
        ds_d    = ((state_d == S_AS) && rd_d) || (state_d == S_CS) || (state_d == S_ACK);
        dtack_d = (state_d == S_ACK);
        berr_d  = (state_d == S_TOUT);
    end

    always_ff @(negedge bclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            rd_q     <= 1'b0;
            as_cnt_q <= '0;
            cs_cnt_q <= '0;
            sreg_n_q <= '1;
            as_q     <= 1'b0;
            ds_q     <= 1'b0;
            dtack_q  <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rd_q     <= rd_d;
            as_cnt_q <= as_cnt_d;
            cs_cnt_q <= cs_cnt_d;
            sreg_n_q <= sreg_n_d;
            as_q     <= as_d;
            ds_q     <= ds_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
        end
    end

    assign SCSI_SREG_n = sreg_n_q;
    assign scsi_as_sig = as_q;
    assign scsi_ds_sig = ds_q;
    assign dtack       = dtack_q;
    assign berr        = berr_q;

endmodule

// File: doc/scsiaccess_mc.md
SCSIACCESS_MC -- requirements
Module: scsiaccess_mc

Interface
REQ-001 SHALL have parameter NCH, default 2: number of chip-select channels, 1..8.
REQ-002 SHALL have parameter DS_DELAY, default 1: write-cycle AS-to-DS delay in bclk cycles, 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 255: CS cycles without SLACK before bus error, 1..255.
REQ-004 SHALL have port bclk  in  1  sole clock; all state updates on its falling edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port scsi_cycle  in  1  decoded register-access cycle; level, sampled on bclk.
REQ-007 SHALL have port chan_sel  in  NCH  one-hot target select, valid while scsi_cycle is high.
REQ-008 SHALL have port DOE  in  1  data output enable from the bus.
REQ-009 SHALL have port DS_n  in  4  bus byte strobes, active low.
REQ-010 SHALL have port READ  in  1  1 = read, 0 = write.
REQ-011 SHALL have port mybus  in  1  board is bus master (DMA); register sequencing suppressed.
REQ-012 SHALL have port SLACK_n  in  NCH  per-channel slave acknowledge, active low.
REQ-013 SHALL have port SCSI_SREG_n  out  NCH  per-channel register chip select, active low.
REQ-014 SHALL have ports scsi_as_sig, scsi_ds_sig, dtack, berr  out  1 each  address strobe, data strobe, cycle acknowledge, bus error.

Function
REQ-015 SHALL register all outputs on falling bclk; no combinational input-to-output path.
REQ-016 SHALL implement states IDLE, AS, CS, ACK, TOUT.
REQ-017 IDLE->AS SHALL occur when scsi_cycle & !mybus & DOE & any DS_n low & chan_sel exactly one-hot; on entry the channel index and READ SHALL be latched.
REQ-018 chan_sel zero or multi-hot SHALL keep IDLE and assert nothing.
REQ-019 AS SHALL last 1 cycle for reads and DS_DELAY cycles for writes (a 4-bit counter), then go to CS.
REQ-020 scsi_as_sig SHALL be 1 in AS, CS, ACK; scsi_ds_sig SHALL be 1 in AS only for reads, and in CS and ACK.
REQ-021 SCSI_SREG_n[ch] of the latched channel SHALL be 0 in CS and ACK; all other bits SHALL be 1.
REQ-022 In CS an 8-bit counter SHALL count from 0 each cycle; SLACK_n[ch] low SHALL go to ACK; the counter reaching TIMEOUT SHALL go to TOUT.
REQ-023 SLACK_n[ch] low in the same cycle as timeout SHALL go to ACK (ack wins).
REQ-024 SLACK_n bits of non-selected channels SHALL be ignored.
REQ-025 ACK SHALL hold dtack=1 with AS/DS/SREG until scsi_cycle is sampled low.
REQ-026 TOUT SHALL drive berr=1, release SREG_n, AS, DS, and hold until scsi_cycle is sampled low.
REQ-027 scsi_cycle sampled low in any state SHALL return to IDLE, with all outputs inactive on that same edge.
REQ-028 mybus & scsi_cycle SHALL force IDLE and drive SCSI_SREG_n[0]=0 (DMA pass-through on channel 0); AS, DS, dtack, berr SHALL be 0.
REQ-029 mybus rising mid-sequence SHALL abort to IDLE on the next edge per REQ-028.
REQ-030 A new cycle SHALL require at least one IDLE cycle between accesses.

Reset
REQ-031 reset high SHALL asynchronously force IDLE, counters 0, SCSI_SREG_n all 1, scsi_as_sig=0, scsi_ds_sig=0, dtack=0, berr=0.
REQ-032 Reset deasserting with scsi_cycle already high SHALL start a sequence only via the REQ-017 conditions on a following edge.

Verification
REQ-033 NCH=2: read, chan_sel=01, SLACK_n[0] low at CS cycle 3 -> edge1 AS=DS=1; edge2 SREG_n=10; dtack=1 on the edge sampling SLACK_n; everything 0/1 the edge after scsi_cycle falls.
REQ-034 Write with DS_DELAY=3, chan_sel=10 -> AS=1 for 3 edges with DS=0, then DS=1 and SREG_n=01.
REQ-035 TIMEOUT=4, no SLACK -> berr=1 at CS count 4, SREG_n=11, AS=DS=0; berr clears when scsi_cycle falls.
REQ-036 SLACK_n low exactly at timeout count -> dtack=1, berr stays 0.
REQ-037 mybus=1 with scsi_cycle high -> SREG_n[0]=0, AS=DS=dtack=0; chan_sel=11 with mybus=0 -> no outputs asserted.
REQ-038 reset pulsed in CS mid-cycle -> all outputs at reset values immediately, independent of bclk.
